// File: rtl/loader_pkg.sv
// Shared types and constants for the framed byte-stream memory loader.
`default_nettype none

package loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_SEL    = 4'd1,
    S_ADDR_L = 4'd2,
    S_ADDR_H = 4'd3,
    S_CNT_L  = 4'd4,
    S_CNT_H  = 4'd5,
    S_DATA_L = 4'd6,
    S_DATA_H = 4'd7,
    S_SUM_L  = 4'd8,
    S_SUM_H  = 4'd9
  } state_t;

  localparam logic [7:0] SEL_IMEM = 8'h49;
  localparam logic [7:0] SEL_DMEM = 8'h44;

  // SEL + ADDR(2) + CNT(2) + SUM(2) bytes surround the 2N data bytes.
  localparam int FRAME_OVERHEAD = 7;

  function automatic int frame_len(input int n_words);
    return 2 * n_words + FRAME_OVERHEAD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_loader.sv
// Framed byte-stream loader: pairs bytes into little-endian words, writes IMEM/DMEM,
// verifies an XOR checksum and holds the CPU in reset until a clean load completes.
`default_nettype none

module mem_loader
  import loader_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic                  mem_sel,
  output logic [WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold
);

  localparam logic [WIDTH:0] DEPTH_C = (WIDTH + 1)'(MEM_DEPTH);

  state_t                  state_q;
  logic [7:0]              lo_q;
  logic [WIDTH-1:0]        base_q;
  logic [15:0]             cnt_q;
  logic [15:0]             idx_q;
  logic [15:0]             sum_q;
  logic                    mem_we_q;
  logic                    mem_sel_q;
  logic [WIDTH-1:0]        mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    error_q;
  logic                    cpu_hold_q;

  logic                    hs;
  logic [15:0]             pair;
  logic [WIDTH:0]          span;

  // Every multi-byte field arrives low byte first; lo_q holds whichever low byte came last.
  assign pair = {in_data, lo_q};
  assign hs   = in_valid && (state_q != S_IDLE);
  assign span = {1'b0, base_q} + (WIDTH + 1)'(pair);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      lo_q        <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_hold_q  <= 1'b1;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      if (state_q == S_IDLE) begin
        if (start) begin
          state_q    <= S_SEL;
          busy_q     <= 1'b1;
          error_q    <= 1'b0;
          cpu_hold_q <= 1'b1;
          sum_q      <= '0;
          idx_q      <= '0;
        end
      end else if (hs) begin
        case (state_q)
          S_SEL: begin
            if (in_data == SEL_IMEM || in_data == SEL_DMEM) begin
              mem_sel_q <= (in_data == SEL_DMEM);
              state_q   <= S_ADDR_L;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end
          end
          S_ADDR_L: begin
            lo_q    <= in_data;
            state_q <= S_ADDR_H;
          end
          S_ADDR_H: begin
            base_q  <= WIDTH'(pair);
            state_q <= S_CNT_L;
          end
          S_CNT_L: begin
            lo_q    <= in_data;
            state_q <= S_CNT_H;
          end
          S_CNT_H: begin
            cnt_q <= pair;
            // Rejecting here keeps every later address inside the target memory.
            if (span > DEPTH_C) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else if (pair == 16'd0) begin
              state_q <= S_SUM_L;
            end else begin
              state_q <= S_DATA_L;
            end
          end
          S_DATA_L: begin
            lo_q    <= in_data;
            state_q <= S_DATA_H;
          end
          S_DATA_H: begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= base_q + WIDTH'(idx_q);
            mem_wdata_q <= DATA_WIDTH'(pair);
            sum_q       <= sum_q ^ pair;
            idx_q       <= idx_q + 16'd1;
            state_q     <= (idx_q == cnt_q - 16'd1) ? S_SUM_L : S_DATA_L;
          end
          S_SUM_L: begin
            lo_q    <= in_data;
            state_q <= S_SUM_H;
          end
          S_SUM_H: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            if (pair == sum_q) begin
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              error_q <= 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready  = (state_q != S_IDLE);
  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cpu_hold  = cpu_hold_q;

endmodule

`default_nettype wire
